// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared encodings for the MDU issue controller: SPECIAL opcode,
//               MDU funct codes, MDU request op codes and the issue FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Op code presented on the MDU request port
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    // Issue/handshake tracking state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_BUSY  = 2'd3
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_decode.sv
`default_nettype none
// ============================================================================
// Module      : mdu_decode
// Description : Combinational classifier for MDU-class instructions.
//               is_md : mult/multu/div/divu (long-running, busy handshake)
//               is_mt : mthi/mtlo (single-cycle write to HI/LO)
//               is_mf : mfhi/mflo (read HI/LO, never issued to the MDU)
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_decode
    import mdu_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_is_md,
    output logic        o_is_mt,
    output logic        o_is_mf,
    output mdu_op_e     o_op
);

    // Only opcode and funct fields take part in classification
    logic w_unused_fields;
    assign w_unused_fields = ^i_instr[25:6];

    // Classify SPECIAL-opcode instructions by funct
    always_comb begin
        o_is_md = 1'b0;
        o_is_mt = 1'b0;
        o_is_mf = 1'b0;
        o_op    = MDU_NONE;
        if (i_instr[31:26] == OPC_SPECIAL) begin
            case (i_instr[5:0])
                FN_MULT:  begin o_is_md = 1'b1; o_op = MDU_MULT;  end
                FN_MULTU: begin o_is_md = 1'b1; o_op = MDU_MULTU; end
                FN_DIV:   begin o_is_md = 1'b1; o_op = MDU_DIV;   end
                FN_DIVU:  begin o_is_md = 1'b1; o_op = MDU_DIVU;  end
                FN_MTHI:  begin o_is_mt = 1'b1; o_op = MDU_MTHI;  end
                FN_MTLO:  begin o_is_mt = 1'b1; o_op = MDU_MTLO;  end
                FN_MFHI,
                FN_MFLO:  o_is_mf = 1'b1;
                default:  ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_issue_ctrl
// Description : Pipeline-side MDU initiator. Issues one registered request per
//               E-stage MDU op, tracks the MDU busy handshake to completion and
//               stalls D while any later MDU-class instruction would collide.
//               Optional feature macro: MDU_ISSUE_TIMEOUT_EN (WAIT-state
//               acknowledge timeout of ACK_TIMEOUT cycles, flags mdu_err).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4,
    parameter int OP_W        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     i_instr_d,
    input  logic [31:0]     i_instr_e,
    input  logic            i_e_valid,
    input  logic [31:0]     i_rs_e,
    input  logic [31:0]     i_rt_e,
    input  logic            i_mdu_busy,
    output logic            o_mdu_req,
    output logic [OP_W-1:0] o_mdu_op,
    output logic [31:0]     o_mdu_a,
    output logic [31:0]     o_mdu_b,
    output logic            o_stall_d,
    output logic            o_mdu_err
);

    logic       w_d_is_md;
    logic       w_d_is_mt;
    logic       w_d_is_mf;
    mdu_op_e    w_d_op;
    logic       w_e_is_md;
    logic       w_e_is_mt;
    logic       w_e_is_mf;
    mdu_op_e    w_e_op;
    logic       w_d_class;
    logic       w_e_issue;
    logic       w_unused_dec;

    mdu_state_e      r_state;
    logic            r_req;
    logic            r_is_md;
    logic            r_err;
    logic [OP_W-1:0] r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;

`ifdef MDU_ISSUE_TIMEOUT_EN
    localparam int              CNT_W       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(ACK_TIMEOUT - 1);
    logic [CNT_W-1:0] r_wait_cnt;
`else
    localparam int c_unused_ack = ACK_TIMEOUT;
`endif

    mdu_decode u_dec_d (
        .i_instr (i_instr_d),
        .o_is_md (w_d_is_md),
        .o_is_mt (w_d_is_mt),
        .o_is_mf (w_d_is_mf),
        .o_op    (w_d_op)
    );

    mdu_decode u_dec_e (
        .i_instr (i_instr_e),
        .o_is_md (w_e_is_md),
        .o_is_mt (w_e_is_mt),
        .o_is_mf (w_e_is_mf),
        .o_op    (w_e_op)
    );

    // D only needs the class; E only needs the issuable subset
    assign w_unused_dec = ^{w_d_op, w_e_is_mf};

    assign w_d_class = w_d_is_md | w_d_is_mt | w_d_is_mf;
    assign w_e_issue = i_e_valid & (w_e_is_md | w_e_is_mt);

    // Hold any MDU-class instruction in D while an op is outstanding or issuing now
    assign o_stall_d = w_d_class & ((r_state != ST_IDLE) | w_e_issue);

    // Issue FSM with registered request, operands and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_is_md    <= 1'b0;
            r_err      <= 1'b0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
`ifdef MDU_ISSUE_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_e_issue) begin
                        r_op    <= OP_W'(w_e_op);
                        r_is_md <= w_e_is_md;
                        r_a     <= i_rs_e;
                        r_b     <= i_rt_e;
                        r_req   <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // mthi/mtlo complete at the MDU's sampling edge, no handshake
                    r_state <= r_is_md ? ST_WAIT : ST_IDLE;
`ifdef MDU_ISSUE_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (i_mdu_busy) begin
                        r_state <= ST_BUSY;
                    end
`ifdef MDU_ISSUE_TIMEOUT_EN
                    else if (r_wait_cnt == c_wait_last) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                ST_BUSY: begin
                    if (!i_mdu_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // An op reaching E while another is outstanding is dropped
            if (w_e_issue && (r_state != ST_IDLE)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_mdu_req = r_req;
    assign o_mdu_op  = r_op;
    assign o_mdu_a   = r_a;
    assign o_mdu_b   = r_b;
    assign o_mdu_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_issue_ctrl
// Description : Self-checking bench for mdu_issue_ctrl. A small pipeline model
//               feeds D/E, a behavioural MDU responder drives busy, and an
//               outstanding-operation reference model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_issue_ctrl;

    localparam int ACK_TIMEOUT = 4;
    localparam int OP_W        = 4;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     instr_d;
    logic [31:0]     instr_e;
    logic            e_valid;
    logic [31:0]     rs_e;
    logic [31:0]     rt_e;
    logic            mdu_busy;
    logic            mdu_req;
    logic [OP_W-1:0] mdu_op;
    logic [31:0]     mdu_a;
    logic [31:0]     mdu_b;
    logic            stall_d;
    logic            mdu_err;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_instr_d  (instr_d),
        .i_instr_e  (instr_e),
        .i_e_valid  (e_valid),
        .i_rs_e     (rs_e),
        .i_rt_e     (rt_e),
        .i_mdu_busy (mdu_busy),
        .o_mdu_req  (mdu_req),
        .o_mdu_op   (mdu_op),
        .o_mdu_a    (mdu_a),
        .o_mdu_b    (mdu_b),
        .o_stall_d  (stall_d),
        .o_mdu_err  (mdu_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding op, described by age and handshake progress
    bit          m_pend = 1'b0;
    int          m_age  = 0;
    bit          m_md   = 1'b0;
    bit          m_seen = 1'b0;
    int          m_wait = 0;
    logic [3:0]  m_op   = '0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    bit          m_err  = 1'b0;

    // Responder: busy window [t_rise, t_fall) in cycle numbers
    bit rsp_en   = 1'b1;
    int rsp_dmax = 0;
    int rsp_lmin = 5;
    int rsp_lmax = 5;
    int cyc      = 0;
    int t_rise   = 0;
    int t_fall   = 0;

    bit          last_stall = 1'b0;
    int          nreq   = 0;
    int          nstall = 0;
    logic [3:0]  req_op = '0;
    logic [31:0] req_a  = '0;
    logic [31:0] req_b  = '0;

    ent_t q[$];
    ent_t d_ent;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_of(input logic [31:0] ins);
        if (ins[31:26] != 6'd0) return 0;
        case (ins[5:0])
            6'd24:   return 1;
            6'd25:   return 2;
            6'd26:   return 3;
            6'd27:   return 4;
            6'd17:   return 5;
            6'd19:   return 6;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_class(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) &&
               (((ins[5:0] >= 6'd16) && (ins[5:0] <= 6'd19)) ||
                ((ins[5:0] >= 6'd24) && (ins[5:0] <= 6'd27)));
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] fn);
        logic [31:0] r;
        r        = $urandom;
        r[31:26] = 6'd0;
        r[5:0]   = fn;
        return r;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        int   k;
        k   = $urandom_range(0, 11);
        e.a = $urandom;
        e.b = $urandom;
        case (k)
            0:  e.ins = mk(6'd24);
            1:  e.ins = mk(6'd25);
            2:  e.ins = mk(6'd26);
            3:  e.ins = mk(6'd27);
            4:  e.ins = mk(6'd16);
            5:  e.ins = mk(6'd17);
            6:  e.ins = mk(6'd18);
            7:  e.ins = mk(6'd19);
            8, 9: e.ins = mk(6'd33);
            default: begin
                e.ins        = $urandom;
                e.ins[31:26] = 6'($urandom_range(1, 63));
            end
        endcase
        return e;
    endfunction

    task automatic push(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        ent_t e;
        e.ins = mk(fn);
        e.a   = a;
        e.b   = b;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_age = 0; m_md = 1'b0; m_seen = 1'b0; m_wait = 0;
        m_op = '0; m_a = '0; m_b = '0; m_err = 1'b0;
        t_rise = 0; t_fall = 0;
    endtask

    // One clock: check at negedge, advance model and responder at posedge
    task automatic cycle();
        int e_op;
        bit e_iss;
        bit exp_stall;
        bit req_seen;
        @(negedge clk);
        e_op      = op_of(instr_e);
        e_iss     = e_valid && (e_op != 0);
        exp_stall = is_class(instr_d) && (m_pend || e_iss);
        chk("req",   {31'd0, mdu_req}, {31'd0, (m_pend && (m_age == 1))});
        chk("op",    {28'd0, mdu_op},  {28'd0, m_op});
        chk("a",     mdu_a, m_a);
        chk("b",     mdu_b, m_b);
        chk("err",   {31'd0, mdu_err}, {31'd0, m_err});
        chk("stall", {31'd0, stall_d}, {31'd0, exp_stall});
        last_stall = exp_stall;
        req_seen   = mdu_req;
        if (mdu_req) begin
            nreq++;
            req_op = mdu_op;
            req_a  = mdu_a;
            req_b  = mdu_b;
        end
        if (stall_d) nstall++;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_pend) begin
            if (e_iss) begin
                m_pend = 1'b1; m_age = 1; m_md = (e_op <= 4); m_seen = 1'b0; m_wait = 0;
                m_op = 4'(e_op); m_a = rs_e; m_b = rt_e;
            end
        end else begin
            if (e_iss) m_err = 1'b1;
            if (m_age == 1) begin
                if (!m_md) m_pend = 1'b0;
                else       m_age  = 2;
            end else if (!m_seen) begin
                if (mdu_busy) m_seen = 1'b1;
                else begin
                    m_wait++;
`ifdef MDU_ISSUE_TIMEOUT_EN
                    if (m_wait == ACK_TIMEOUT) begin
                        m_pend = 1'b0;
                        m_err  = 1'b1;
                    end
`endif
                end
            end else if (!mdu_busy) begin
                m_pend = 1'b0;
            end
        end
        if (req_seen && rsp_en && m_md && rst_n) begin
            t_rise = cyc + 1 + $urandom_range(0, rsp_dmax);
            t_fall = t_rise + $urandom_range(rsp_lmin, rsp_lmax);
        end
        cyc++;
        #1;
        mdu_busy = (cyc >= t_rise) && (cyc < t_fall);
    endtask

    // Advance the F/D/E pipeline, inserting a bubble into E on stall
    task automatic pipe(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            if (!last_stall) begin
                instr_e = instr_d;
                rs_e    = d_ent.a;
                rt_e    = d_ent.b;
                e_valid = 1'b1;
                if (q.size() > 0) begin
                    d_ent = q.pop_front();
                end else begin
                    d_ent.ins = 32'd0;
                    d_ent.a   = $urandom;
                    d_ent.b   = $urandom;
                end
                instr_d = d_ent.ins;
            end else begin
                e_valid = 1'b0;
            end
        end
    endtask

    task automatic clear_d();
        instr_d   = 32'd0;
        d_ent.ins = 32'd0;
        d_ent.a   = 32'd0;
        d_ent.b   = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int s0;
        rst_n    = 1'b0;
        instr_d  = mk(6'd16);
        instr_e  = mk(6'd24);
        e_valid  = 1'b1;
        rs_e     = 32'h1111_1111;
        rt_e     = 32'h2222_2222;
        mdu_busy = 1'b0;
        d_ent.ins = instr_d; d_ent.a = 32'd0; d_ent.b = 32'd0;

        // Reset: outputs zero, stall follows e_issue only
        cycle();
        rst_n   = 1'b1;
        instr_e = 32'd0;
        e_valid = 1'b0;
        clear_d();
        pipe(2);

        // mult -3 * 7
        rsp_dmax = 1; rsp_lmin = 5; rsp_lmax = 5;
        n0 = nreq;
        push(6'd24, 32'hFFFF_FFFD, 32'd7);
        pipe(16);
        chk("mult_nreq", nreq - n0, 1);
        chk("mult_op",   {28'd0, req_op}, 32'd1);
        chk("mult_a",    req_a, 32'hFFFF_FFFD);
        chk("mult_b",    req_b, 32'd7);

        // divu with mflo behind it, MDU busy for 10 cycles
        rsp_dmax = 0; rsp_lmin = 10; rsp_lmax = 10;
        n0 = nreq; s0 = nstall;
        push(6'd27, 32'd100, 32'd9);
        push(6'd18, 32'd0, 32'd0);
        pipe(22);
        chk("divu_nreq",   nreq - n0, 1);
        chk("divu_op",     {28'd0, req_op}, 32'd4);
        chk("divu_stalls", nstall - s0, 13);

        // mthi then mfhi: two stall cycles, no handshake
        n0 = nreq; s0 = nstall;
        push(6'd17, 32'hDEAD_BEEF, 32'h0);
        push(6'd16, 32'h0, 32'h0);
        pipe(8);
        chk("mthi_nreq",   nreq - n0, 1);
        chk("mthi_op",     {28'd0, req_op}, 32'd5);
        chk("mthi_a",      req_a, 32'hDEAD_BEEF);
        chk("mthi_stalls", nstall - s0, 2);

        // Bubble carrying a mult encoding
        n0 = nreq; s0 = nstall;
        instr_e = mk(6'd24); e_valid = 1'b0;
        instr_d = mk(6'd16); d_ent.ins = instr_d;
        cycle();
        cycle();
        chk("bubble_stalls", nstall - s0, 0);
        chk("bubble_nreq",   nreq - n0, 0);
        clear_d();
        instr_e = 32'd0;

        // Asynchronous reset while BUSY
        rsp_dmax = 0; rsp_lmin = 6; rsp_lmax = 6;
        push(6'd24, 32'd1, 32'd2);
        pipe(5);
        chk("pre_rst_op", {28'd0, mdu_op}, 32'd1);
        chk("pre_rst_a",  mdu_a, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'd0, mdu_req}, 32'd0);
        chk("rst_op",  {28'd0, mdu_op},  32'd0);
        chk("rst_a",   mdu_a, 32'd0);
        chk("rst_b",   mdu_b, 32'd0);
        chk("rst_err", {31'd0, mdu_err}, 32'd0);
        model_reset();
        mdu_busy = 1'b0;
        instr_e = 32'd0; e_valid = 1'b0;
        q.delete();
        clear_d();
        cycle();
        rst_n = 1'b1;
        n0 = nreq;
        push(6'd24, 32'h1234_5678, 32'd9);
        pipe(14);
        chk("post_rst_nreq", nreq - n0, 1);
        chk("post_rst_op",   {28'd0, req_op}, 32'd1);
        chk("post_rst_a",    req_a, 32'h1234_5678);

        // Randomized legal instruction stream
        rsp_dmax = 2; rsp_lmin = 1; rsp_lmax = 6;
        for (int i = 0; i < 40; i++) q.push_back(rand_ent());
        pipe(400);
        q.delete();
        pipe(16);

`ifdef MDU_ISSUE_TIMEOUT_EN
        // No acknowledge: WAIT times out and releases the stall
        rsp_en = 1'b0;
        push(6'd26, 32'd5, 32'd6);
        push(6'd16, 32'd0, 32'd0);
        pipe(16);
        chk("to_err", {31'd0, mdu_err}, 32'd1);
        rsp_en = 1'b1;
`endif

        // Op forced into E while BUSY is dropped and flags an error
        rsp_dmax = 0; rsp_lmin = 8; rsp_lmax = 8;
        push(6'd24, 32'd3, 32'd4);
        pipe(5);
        n0 = nreq;
        instr_e = mk(6'd25); e_valid = 1'b1; rs_e = 32'hAAAA_0000; rt_e = 32'h5555;
        cycle();
        instr_e = 32'd0; e_valid = 1'b0;
        pipe(12);
        chk("drop_nreq", nreq - n0, 0);
        chk("drop_err",  {31'd0, mdu_err}, 32'd1);
        chk("drop_a",    mdu_a, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

Pipeline-side initiator for the multiply/divide unit: decodes MDU-class instructions in D and E, issues one registered request per E-stage MDU op, and tracks the unit's busy handshake until completion. It also generates the D-stage stall that keeps every later MDU-class instruction (mult/div/mthi/mtlo/mfhi/mflo) out of E while an operation is outstanding. It sits between the E-stage operand forwarding muxes and the MDU request port; its stall output is ORed into the main hazard unit.

## Interface
- ACK_TIMEOUT, 4: cycles allowed in WAIT for mdu_busy to rise (only with timeout feature)
- OP_W, 4: width of mdu_op
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset); one clock domain only
- instr_d  in  32  instruction in D stage
- instr_e  in  32  instruction in E stage
- e_valid  in  1  E stage holds a real instruction (0 = bubble)
- rs_e  in  32  forwarded rs operand in E
- rt_e  in  32  forwarded rt operand in E
- mdu_busy  in  1  MDU busy (responder's acknowledge/occupancy)
- mdu_req  out  1  one-cycle request pulse
- mdu_op  out  OP_W  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
- mdu_a  out  32  latched rs_e
- mdu_b  out  32  latched rt_e
- stall_d  out  1  freeze F/D, insert bubble into E
- mdu_err  out  1  sticky protocol error

## Operation
- Decode: opcode instr[31:26]==0 and funct: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011; "MDU-class" = any of the eight.
- e_issue = e_valid & instr_e is mult/multu/div/divu/mthi/mtlo (mfhi/mflo never issue).
- FSM states IDLE, ISSUE, WAIT, BUSY.
- IDLE: e_issue -> latch op/rs_e/rt_e into mdu_op/mdu_a/mdu_b, mdu_req<=1, go ISSUE. Otherwise stay.
- ISSUE: mdu_req<=0; mult/div class -> WAIT; mthi/mtlo -> IDLE.
- WAIT: mdu_busy=1 -> BUSY; else stay (timeout rule in Configuration).
- BUSY: mdu_busy=0 -> IDLE.
- mdu_op/mdu_a/mdu_b hold their value until next issue (not cleared on return to IDLE).
- stall_d = d_mdu_class & ((state != IDLE) | e_issue). Combinational from state and inputs.
- e_issue while state != IDLE: op dropped, no request, mdu_err<=1 (stall_d makes this unreachable in legal flow).
- mdu_err clears only on reset.

## Timing
- Reset (async assert): state IDLE, mdu_req 0, mdu_op 0, mdu_a/mdu_b 0, mdu_err 0; stall_d then depends only on e_issue.
- Issue latency: E-stage op in cycle N -> mdu_req=1 in cycle N+1 only.
- MDU responder samples request at rising edge ending N+1; mdu_busy visible from N+2.
- mthi/mtlo: stall_d high in N and N+1; mfhi/mflo behind it enters E at N+2, after HI/LO written.
- mult (MDU 5-cycle busy): stall_d covers N through last BUSY cycle; released the cycle state returns IDLE.
- Reset mid-BUSY/WAIT: immediate return to IDLE, mdu_req drops asynchronously; the MDU is reset by the same net.
- Back-to-back: a second MDU op cannot reach E before the cycle after IDLE is re-entered.

## Configuration
- MDU_ISSUE_TIMEOUT_EN defined: counter in WAIT; after ACK_TIMEOUT cycles with mdu_busy=0, set mdu_err, go IDLE (releases stall).
- Undefined: no counter; WAIT holds indefinitely; mdu_err set only by dropped ops. ACK_TIMEOUT unused.

## Structure
- Package mdu_pkg: op encodings (MDU_NONE..MDU_MTLO), funct constants, SPECIAL opcode, FSM state type.
- Sub-module mdu_decode: combinational instruction classifier (is_md, is_mt, is_mf, op code), instantiated for instr_d and instr_e.

## Test plan
- mult rs=-3 rt=7 in E at N -> mdu_req=1 only at N+1, mdu_op=1, mdu_a=32'hFFFFFFFD, mdu_b=7; FSM ISSUE->WAIT->BUSY->IDLE following mdu_busy.
- divu in E, mflo in D, MDU busy 10 cycles -> stall_d high from N until state IDLE, then mflo advances; no second mdu_req.
- mthi rs=32'hDEADBEEF then mfhi -> one req with op 5, stall_d exactly 2 cycles, no WAIT.
- Bubble (e_valid=0) with mult encoding in instr_e -> no req, no stall, state IDLE.
- reset=0 during BUSY -> all outputs to reset values immediately; after release, fresh mult issues normally.
- MDU_ISSUE_TIMEOUT_EN, ACK_TIMEOUT=4, mdu_busy held 0 -> WAIT 4 cycles, mdu_err=1, IDLE, stall_d released; forced e_issue in BUSY (stall overridden) -> drop, mdu_err=1.
